// File: rtl/stage_1.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack port, feeds decode through an output+skid pair.
// Optional: define STAGE_1_MISALIGN_TRAP_EN to trap on redirects to non-word-aligned targets.
module stage_1 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_b_taken,
  input  logic [31:0] i_b_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        valid,
  output logic        misalign
);

`ifdef STAGE_1_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {REQ, DROP, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {REQ, DROP, HOLD} state_t;
`endif

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] tgt;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic [31:0] target;
  logic        bad_tgt;

  assign target   = {i_b_pc[31:2], 2'b00};
  assign mem_req  = (state == REQ) || (state == DROP);
  assign mem_addr = pc_reg;

`ifdef STAGE_1_MISALIGN_TRAP_EN
  assign bad_tgt  = (i_b_pc[1:0] != 2'b00);
  assign misalign = (state == TRAP);
`else
  logic unused_lo;
  assign unused_lo = ^i_b_pc[1:0];
  assign bad_tgt   = 1'b0;
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= REQ;
      pc_reg     <= RESET_PC;
      tgt        <= RESET_PC;
      skid_inst  <= NOP;
      skid_pc    <= RESET_PC;
      skid_valid <= 1'b0;
      valid      <= 1'b0;
      inst       <= NOP;
      pc         <= RESET_PC;
    end else begin
      case (state)
        REQ: begin
          if (i_b_taken) begin
            valid      <= 1'b0;
            inst       <= NOP;
            skid_valid <= 1'b0;
            if (bad_tgt) begin
`ifdef STAGE_1_MISALIGN_TRAP_EN
              state <= TRAP;
`endif
            end else if (i_mem_ack) begin
              pc_reg <= target;
            end else begin
              // word in flight belongs to the old path; swallow it in DROP
              tgt   <= target;
              state <= DROP;
            end
          end else if (i_mem_ack) begin
            pc_reg <= pc_reg + 32'd4;
            if (!valid || !i_stall) begin
              inst  <= i_mem_data;
              pc    <= pc_reg;
              valid <= 1'b1;
            end else begin
              skid_inst  <= i_mem_data;
              skid_pc    <= pc_reg;
              skid_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (!i_stall) begin
            valid <= 1'b0;
            inst  <= NOP;
          end
        end
        DROP: begin
          if (i_b_taken) begin
            valid      <= 1'b0;
            inst       <= NOP;
            skid_valid <= 1'b0;
            if (bad_tgt) begin
`ifdef STAGE_1_MISALIGN_TRAP_EN
              state <= TRAP;
`endif
            end else if (i_mem_ack) begin
              pc_reg <= target;
              state  <= REQ;
            end else begin
              tgt <= target;
            end
          end else if (i_mem_ack) begin
            pc_reg <= tgt;
            state  <= REQ;
          end
        end
        HOLD: begin
          if (i_b_taken) begin
            valid      <= 1'b0;
            inst       <= NOP;
            skid_valid <= 1'b0;
            if (bad_tgt) begin
`ifdef STAGE_1_MISALIGN_TRAP_EN
              state <= TRAP;
`endif
            end else begin
              pc_reg <= target;
              state  <= REQ;
            end
          end else if (!i_stall && skid_valid) begin
            inst       <= skid_inst;
            pc         <= skid_pc;
            valid      <= 1'b1;
            skid_valid <= 1'b0;
            state      <= REQ;
          end
        end
`ifdef STAGE_1_MISALIGN_TRAP_EN
        TRAP: begin
          // sticky until reset; a late ack from an abandoned request is ignored here
          valid <= 1'b0;
          inst  <= NOP;
        end
`endif
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_1.sv
// Randomized bench for stage_1 against a queue-level model of the fetch/decode hand-off.
module tb_stage_1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, b_taken, ack;
  logic [31:0] b_pc, mem_data;
  logic        mem_req, valid, misalign;
  logic [31:0] mem_addr, inst, pc;

  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_inst, w_pc;

  stage_1 dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_b_taken(b_taken), .i_b_pc(b_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .i_mem_ack(ack), .i_mem_data(mem_data),
    .inst(inst), .pc(pc), .valid(valid), .misalign(misalign)
  );

  stage_1 #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_stall(1'b0), .i_b_taken(1'b0), .i_b_pc(32'h0),
    .mem_req(w_req), .mem_addr(w_addr), .i_mem_ack(1'b1), .i_mem_data(32'h0),
    .inst(w_inst), .pc(w_pc), .valid(w_valid), .misalign(w_mis)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // model: words visible to decode (head = output, second = skid), fetch pointer, pending drop
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_ptr, m_tgt;
  bit          m_drop, m_trap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_req();
    return !m_trap && (m_drop || q_pc.size() < 2);
  endfunction

  task automatic model_reset();
    m_ptr = 32'h0; m_tgt = 32'h0; m_drop = 0; m_trap = 0;
    q_pc.delete(); q_inst.delete();
  endtask

  task automatic step(input bit s, input bit bt, input logic [31:0] bpc, input bit a,
                      input logic [31:0] d);
    bit req, bad;
    req = m_req();
    bad = 0;
`ifdef STAGE_1_MISALIGN_TRAP_EN
    bad = (bpc[1:0] != 2'b00);
`endif
    if (m_trap) begin
    end else if (bt) begin
      q_pc.delete(); q_inst.delete();
      if (bad) begin
        m_trap = 1; m_drop = 0;
      end else if (req && !a) begin
        m_drop = 1; m_tgt = bpc & ~32'h3;
      end else begin
        m_drop = 0; m_ptr = bpc & ~32'h3;
      end
    end else if (m_drop) begin
      if (a) begin m_drop = 0; m_ptr = m_tgt; end
    end else begin
      if (!s && q_pc.size() > 0) begin q_pc.delete(0); q_inst.delete(0); end
      if (req && a) begin
        q_pc.push_back(m_ptr); q_inst.push_back(d);
        m_ptr = m_ptr + 32'd4;
      end
    end
  endtask

  task automatic compare();
    chk("valid", {31'b0, valid}, {31'b0, q_pc.size() > 0});
    chk("inst", inst, (q_pc.size() > 0) ? q_inst[0] : NOP);
    if (q_pc.size() > 0) chk("pc", pc, q_pc[0]);
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_req()});
    if (m_req()) chk("mem_addr", mem_addr, m_ptr);
    chk("misalign", {31'b0, misalign}, {31'b0, m_trap});
  endtask

  task automatic cycle(input bit s, input bit bt, input logic [31:0] bpc, input bit a_in);
    bit a;
    a        = a_in && m_req();
    stall    = s;
    b_taken  = bt;
    b_pc     = bpc;
    ack      = a;
    mem_data = a ? mem_word(m_ptr) : $urandom;
    step(s, bt, bpc, a, mem_data);
    @(posedge clk); #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_pc", pc, 32'h0);
    compare();
  endtask

  initial begin
    logic [31:0] bpc;
    rst = 1'b1; stall = 0; b_taken = 0; b_pc = 0; ack = 0; mem_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h1);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);

    // back-to-back same-cycle acks; wrap instance fetches FFFFFFFC then 0
    cycle(0, 0, 32'h0, 1);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_valid", {31'b0, w_valid}, 32'h1);
    chk("wrap_inst", w_inst, 32'h0);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_req", {30'b0, w_req, w_mis}, 32'h2);
    repeat (10) cycle(0, 0, 32'h0, 1);

    // no ack for 3 cycles, then stall into HOLD and redirect with skid full
    repeat (3) cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    repeat (4) cycle(1, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 1, 32'h200, 0);
    cycle(0, 0, 32'h0, 1);
    // redirect while waiting for ack, late ack dropped
    cycle(0, 1, 32'h100, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    repeat (3) cycle(0, 0, 32'h0, 1);

    for (int i = 0; i < 3000; i++) begin
      bpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
`ifndef STAGE_1_MISALIGN_TRAP_EN
      bpc[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bpc[31:12] = 20'($urandom);
`endif
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 7, bpc,
            $urandom_range(0, 99) < 60);
    end

`ifdef STAGE_1_MISALIGN_TRAP_EN
    cycle(0, 0, 32'h0, 1);
    cycle(0, 1, 32'h102, 0);
    chk("trap_req", {31'b0, mem_req}, 32'h0);
    chk("trap_mis", {31'b0, misalign}, 32'h1);
    for (int i = 0; i < 20; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), 32'h40, 1);
    do_reset();
    repeat (5) cycle(0, 0, 32'h0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
